// File: rtl/prim_chain_pkg.sv
`timescale 1ns/1ps
// prim_chain_pkg
// Shared definitions for the pipelined XOR/NOT primitive chain.
//   MAX_W       widest data word the helper function handles (32 pairs)
//   data_width  data width in bits for a given number of 2-bit lanes
//   prim_apply  one application of the per-pair primitive (h,l) -> (h^l, ~l)
// Optional feature macro used by the top: PRIM_CHAIN_PERF_EN.
package prim_chain_pkg;

  localparam int MAX_W = 64;

  function automatic int data_width(input int pairs);
    return 2 * pairs;
  endfunction

  // Pairs at index >= pairs pass through untouched, so callers can
  // zero-extend a narrower word and truncate the result.
  function automatic logic [MAX_W-1:0] prim_apply(input logic [MAX_W-1:0] word,
                                                  input int pairs);
    logic [MAX_W-1:0] r;
    r = word;
    for (int j = 0; j < MAX_W / 2; j++) begin
      if (j < pairs) begin
        r[2*j+1] = word[2*j+1] ^ word[2*j];
        r[2*j]   = ~word[2*j];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/prim_chain_stage.sv
`timescale 1ns/1ps
// prim_chain_stage
// One primitive application followed by a valid/ready register slice.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   up_valid     word offered by the previous stage (or the block input)
//   up_data      word before this stage's primitive
//   dn_ready     next stage (or block output) can take this stage's word
//   dn_valid     this stage holds a word
//   dn_data      held word, primitive already applied
// The matching up_ready (!v || dn_ready) is computed by the top from all
// stage valids, which keeps the ready path free of a stage-to-stage loop.
module prim_chain_stage
  import prim_chain_pkg::*;
#(
  parameter  int IO_PAIRS = 5,
  localparam int W        = data_width(IO_PAIRS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  input  logic         dn_ready,
  output logic         dn_valid,
  output logic [W-1:0] dn_data
);

  logic         v;
  logic [W-1:0] d;
  logic         ready;
  logic [W-1:0] d_next;

  // Empty, or our word leaves this cycle.
  assign ready  = !v || dn_ready;
  assign d_next = W'(prim_apply(MAX_W'(up_data), IO_PAIRS));

  always_ff @(posedge clk) begin
    if (rst) begin
      v <= 1'b0;
      d <= '0;
    end else if (ready) begin
      v <= up_valid;
      // Data only captured for a real word, so X on an idle input never lands.
      if (up_valid) d <= d_next;
    end
  end

  assign dn_valid = v;
  assign dn_data  = d;

endmodule

// File: rtl/pipelined_prim_chain.sv
`timescale 1ns/1ps
// pipelined_prim_chain
// DEPTH serial primitive stages, each followed by an elastic register slice.
// One word per cycle at full throughput; capacity DEPTH words.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake, in_data W bits
//   out_valid/out_ready downstream handshake, out_data W bits
//   perf_in_cnt, perf_out_cnt  (only with PRIM_CHAIN_PERF_EN) transfer counters
// Optional feature macro: PRIM_CHAIN_PERF_EN.
module pipelined_prim_chain
  import prim_chain_pkg::*;
#(
  parameter  int IO_PAIRS = 5,
  parameter  int DEPTH    = 1,
  localparam int W        = data_width(IO_PAIRS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
`ifdef PRIM_CHAIN_PERF_EN
  ,
  output logic [31:0]  perf_in_cnt,
  output logic [31:0]  perf_out_cnt
`endif
);

  // vld[k]/dat[k] feed stage k; vld[DEPTH]/dat[DEPTH] is the block output.
  // rdy[k] is the ready seen by whoever drives stage k.
  logic [DEPTH:0]        vld;
  logic [DEPTH:0]        rdy;
  logic [DEPTH:0][W-1:0] dat;

  assign vld[0]     = in_valid;
  assign dat[0]     = in_data;
  assign rdy[DEPTH] = out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    // Unrolled ready chain: stage k can load if any stage at or after it is
    // empty (the whole tail shifts along) or the output is being taken.
    assign rdy[k] = out_ready | ~(&vld[DEPTH:k+1]);

    prim_chain_stage #(.IO_PAIRS(IO_PAIRS)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_valid (vld[k]),
      .up_data  (dat[k]),
      .dn_ready (rdy[k+1]),
      .dn_valid (vld[k+1]),
      .dn_data  (dat[k+1])
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld[DEPTH];
  assign out_data  = dat[DEPTH];

`ifdef PRIM_CHAIN_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_in_cnt  <= '0;
      perf_out_cnt <= '0;
    end else begin
      if (in_valid && in_ready)   perf_in_cnt  <= perf_in_cnt + 32'd1;
      if (out_valid && out_ready) perf_out_cnt <= perf_out_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_prim_chain.sv
`timescale 1ns/1ps
// tb_pipelined_prim_chain
// Four instances (DEPTH 1..4, IO_PAIRS 5) share one stimulus stream; each has
// its own expected-value queue filled on accept and drained by the monitor.
// Perf counter checks are included when PRIM_CHAIN_PERF_EN is defined.
module tb_pipelined_prim_chain;
  import prim_chain_pkg::*;

  localparam int ND = 4;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic out_ready;
  logic [9:0] in_data;

  logic [ND-1:0]       in_ready_v;
  logic [ND-1:0]       out_valid_v;
  logic [ND-1:0][9:0]  out_data_v;
`ifdef PRIM_CHAIN_PERF_EN
  logic [ND-1:0][31:0] perf_in_v;
  logic [ND-1:0][31:0] perf_out_v;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int acc_cnt [ND];
  int out_cnt [ND];
  logic [9:0] exp_q [ND][$];
  logic       held_v [ND];
  logic [9:0] held_d [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    pipelined_prim_chain #(.IO_PAIRS(5), .DEPTH(g + 1)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready_v[g]),
      .in_data      (in_data),
      .out_valid    (out_valid_v[g]),
      .out_ready    (out_ready),
      .out_data     (out_data_v[g])
`ifdef PRIM_CHAIN_PERF_EN
      ,
      .perf_in_cnt  (perf_in_v[g]),
      .perf_out_cnt (perf_out_v[g])
`endif
    );
  end

  // Closed form: two applications invert every high bit, four are identity.
  function automatic logic [9:0] model(input logic [9:0] w, input int depth);
    logic [63:0] t;
    case (depth % 4)
      0: return w;
      1: begin t = prim_apply(64'(w), 5); return t[9:0]; end
      2: return w ^ 10'h2AA;
      default: begin t = prim_apply(64'(w ^ 10'h2AA), 5); return t[9:0]; end
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Accepted words are scored at the negedge before the accepting edge.
  task automatic tick();
    @(negedge clk);
    if (rst) begin
      for (int g = 0; g < ND; g++) exp_q[g].delete();
    end else begin
      for (int g = 0; g < ND; g++) begin
        if (in_valid && in_ready_v[g]) begin
          exp_q[g].push_back(model(in_data, g + 1));
          acc_cnt[g]++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int g = 0; g < ND; g++) held_v[g] = 1'b0;
    end else begin
      for (int g = 0; g < ND; g++) begin
        if (held_v[g]) begin
          check($sformatf("stall_valid_d%0d", g + 1), 32'(out_valid_v[g]), 32'd1);
          check($sformatf("stall_data_d%0d", g + 1), 32'(out_data_v[g]), 32'(held_d[g]));
        end
        if (out_valid_v[g] && out_ready) begin
          out_cnt[g]++;
          if (exp_q[g].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_out_d%0d: got %h expected no output", g + 1, out_data_v[g]);
          end else begin
            check($sformatf("out_data_d%0d", g + 1), 32'(out_data_v[g]), 32'(exp_q[g].pop_front()));
          end
        end
        held_v[g] = out_valid_v[g] && !out_ready;
        held_d[g] = out_data_v[g];
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap [ND];
    int first_seen [ND];
    int bubbles;

    for (int g = 0; g < ND; g++) begin
      acc_cnt[g] = 0; out_cnt[g] = 0; held_v[g] = 1'b0; held_d[g] = '0;
    end
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    tick(); tick();
    rst = 1'b0;
    for (int g = 0; g < ND; g++) begin
      check($sformatf("rst_out_valid_d%0d", g + 1), 32'(out_valid_v[g]), 32'd0);
      check($sformatf("rst_out_data_d%0d", g + 1), 32'(out_data_v[g]), 32'd0);
      check($sformatf("rst_in_ready_d%0d", g + 1), 32'(in_ready_v[g]), 32'd1);
    end

    // Single zero word: known closed-form outputs at each depth.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 10'h000;
    tick();
    in_valid = 1'b0;
    check("zero_valid_d1", 32'(out_valid_v[0]), 32'd1);
    check("zero_data_d1", 32'(out_data_v[0]), 32'h155);
    tick();
    check("zero_valid_d2", 32'(out_valid_v[1]), 32'd1);
    check("zero_data_d2", 32'(out_data_v[1]), 32'h2AA);
    tick();
    check("zero_data_d3", 32'(out_data_v[2]), 32'h3FF);
    tick();
    check("zero_valid_d4", 32'(out_valid_v[3]), 32'd1);
    check("zero_data_d4", 32'(out_data_v[3]), 32'h000);
    tick();

    // Back-to-back stream 0..63 with out_ready high: no bubbles.
    for (int g = 0; g < ND; g++) snap[g] = out_cnt[g];
    bubbles = 0;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1; in_data = 10'(i);
      if (in_ready_v != '1) bubbles++;
      tick();
    end
    in_valid = 1'b0;
    repeat (5) tick();
    check("stream_bubbles", 32'(bubbles), 32'd0);
    for (int g = 0; g < ND; g++)
      check($sformatf("stream_count_d%0d", g + 1), 32'(out_cnt[g] - snap[g]), 32'd64);

    // Fill with out_ready low: each instance takes exactly DEPTH words.
    out_ready = 1'b0;
    for (int g = 0; g < ND; g++) snap[g] = acc_cnt[g];
    repeat (6) begin
      in_valid = 1'b1; in_data = 10'($urandom);
      tick();
    end
    for (int g = 0; g < ND; g++) begin
      check($sformatf("fill_accepts_d%0d", g + 1), 32'(acc_cnt[g] - snap[g]), 32'(g + 1));
      check($sformatf("fill_in_ready_d%0d", g + 1), 32'(in_ready_v[g]), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) tick();
    for (int g = 0; g < ND; g++) begin
      check($sformatf("drain_empty_d%0d", g + 1), 32'(exp_q[g].size()), 32'd0);
      check($sformatf("drain_valid_d%0d", g + 1), 32'(out_valid_v[g]), 32'd0);
    end

    // Reset with words in flight, then first-word latency.
    out_ready = 1'b0;
    repeat (3) begin
      in_valid = 1'b1; in_data = 10'($urandom);
      tick();
    end
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int g = 0; g < ND; g++) begin
      check($sformatf("midrst_valid_d%0d", g + 1), 32'(out_valid_v[g]), 32'd0);
      check($sformatf("midrst_data_d%0d", g + 1), 32'(out_data_v[g]), 32'd0);
      check($sformatf("midrst_in_ready_d%0d", g + 1), 32'(in_ready_v[g]), 32'd1);
      first_seen[g] = 0;
    end
    out_ready = 1'b1; in_valid = 1'b1; in_data = 10'($urandom);
    tick();
    in_valid = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      for (int g = 0; g < ND; g++)
        if (first_seen[g] == 0 && out_valid_v[g]) first_seen[g] = t;
      tick();
    end
    for (int g = 0; g < ND; g++)
      check($sformatf("latency_d%0d", g + 1), 32'(first_seen[g]), 32'(g + 1));

    // Random valid/ready toggling.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = 10'($urandom);
      tick();
    end

`ifdef PRIM_CHAIN_PERF_EN
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    repeat (100) begin
      in_valid = 1'b1; in_data = 10'($urandom);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    for (int g = 0; g < ND; g++) begin
      check($sformatf("perf_in_d%0d", g + 1), perf_in_v[g], 32'd100);
      check($sformatf("perf_out_d%0d", g + 1), perf_out_v[g], 32'(100 - (g + 1)));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int g = 0; g < ND; g++) begin
      check($sformatf("perf_in_rst_d%0d", g + 1), perf_in_v[g], 32'd0);
      check($sformatf("perf_out_rst_d%0d", g + 1), perf_out_v[g], 32'd0);
    end
`endif

    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) tick();
    for (int g = 0; g < ND; g++)
      check($sformatf("final_empty_d%0d", g + 1), 32'(exp_q[g].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_prim_chain.md
Name: pipelined_prim_chain

Overview:
- Pipelined, elastic successor to the combinational XOR/NOT primitive chain used as a simulator correctness benchmark.
- IO_PAIRS bit-pairs pass through DEPTH serial primitive stages. A register slice with a valid/ready handshake follows each stage, so depth scales without long combinational paths.
- Gives the correctness suite a sequential, back-pressured workload with known closed-form outputs.

Parameters:
- IO_PAIRS, 5, number of 2-bit lanes; data width W = 2*IO_PAIRS.
- DEPTH, 1, number of serial primitive stages and register slices; must be >= 1.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word present.
- in_ready  output  1  block accepts word this cycle.
- in_data  input  W  input word; pair j = {in_data[2j+1], in_data[2j]}.
- out_valid  output  1  result word present.
- out_ready  input  1  downstream accepts result.
- out_data  output  W  result after DEPTH primitive applications.

Behaviour:
- Primitive per pair (h,l) -> (h^l, ~l); all pairs are independent. Two applications give (~h, l); four give identity.
- Stage k (0..DEPTH-1) holds v[k] and d[k]. d[k] is loaded with prim(d[k-1]), or prim(in_data) for k=0.
- Advance rule: stage k may load when v[k]=0 or stage k advances out this cycle. Stage DEPTH-1 advances out on out_valid&&out_ready. Stage k<DEPTH-1 advances out when stage k+1 loads.
- in_ready = ready of stage 0. This is combinational through the chain and gives full throughput: one word per cycle with no bubbles when out_ready=1.
- Transfer occurs on valid&&ready at each interface. Data is never dropped or duplicated, and order is preserved.
- out_valid = v[DEPTH-1]; out_data = d[DEPTH-1].
- Latency: a word accepted at edge n is visible on out_data after edge n+DEPTH-1, i.e. DEPTH cycles accept-to-accept with no stall.
- Capacity: DEPTH words. When all v=1 and out_ready=0, in_ready=0.
- Simultaneous events:
  - Full pipe with out_ready=1 and in_valid=1: accepts and emits in the same cycle.
  - Pipe empty: in_ready=1 regardless of out_ready.
- out_ready deasserting holds out_data stable until it is taken.
- Reset, including mid-operation: all v[k]=0 and all d[k]=0 on the next edge. In-flight words are discarded. After that edge out_valid=0, out_data=0 and in_ready=1.
- in_data is ignored when in_valid=0. X on in_data is allowed while in_valid=0.

Optional Feature:
- PRIM_CHAIN_PERF_EN defined:
  - Adds outputs perf_in_cnt[31:0] and perf_out_cnt[31:0].
  - Each counts accepted input and output transfers and wraps modulo 2^32.
  - Both are cleared by rst.
  - Counts are valid from the edge after the transfer.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package prim_chain_pkg:
  - function prim_apply(word, pairs) implementing the per-pair primitive. The bench's reference model uses the same function.
  - localparam-style helper for W.
- One sub-module prim_chain_stage: one primitive plus register slice with valid/ready.
- The top instantiates DEPTH of these in a generate loop and wires the ready chain.

Test Plan:
- IO_PAIRS=5, DEPTH=1, reset then in_data=10'h000 with in_valid=1 and out_ready=1 -> next cycle out_valid=1, out_data=10'h155.
- IO_PAIRS=5, DEPTH=2, in_data=10'h000 -> after 2 cycles out_data=10'h2AA. Stream 0..63 back-to-back -> 64 outputs on consecutive cycles matching prim_apply twice, in order.
- DEPTH=4, random stream -> out_data equals in_data (identity) with latency 4. out_ready held low fills the pipe -> in_ready=0 after 4 accepts. Releasing out_ready drains all 4 words unchanged.
- DEPTH=3, random in_valid/out_ready toggling at 50% for 10k cycles -> scoreboard: no loss, no duplication, order preserved, out_data stable while out_valid&&!out_ready.
- Mid-stream rst=1 for one cycle with 3 words in flight -> next cycle out_valid=0, out_data=0, in_ready=1. The first post-reset word emerges after DEPTH cycles.
- PRIM_CHAIN_PERF_EN: 100 accepts and 97 emits (3 stalled) -> perf_in_cnt=100, perf_out_cnt=97. rst -> both 0.
